// File: rtl/goofy_io_responder.sv
// GoofyCore IO-bus responder: 4-port window with a console TX FIFO, a single-byte
// RX holding register, a sticky-flag status port and a scratch register.
module goofy_io_responder #(
  parameter logic [7:0]  BASE     = 8'hF0,
  parameter int unsigned TX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       res,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_wdata,
  input  logic       io_wr,
  input  logic       io_rd,
  output logic [7:0] io_rdata,
  output logic       io_ack,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_strobe
);

  localparam int unsigned PW = $clog2(TX_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(TX_DEPTH);

  typedef enum logic [1:0] {
    PORT_TX      = 2'd0,
    PORT_STATUS  = 2'd1,
    PORT_RX      = 2'd2,
    PORT_SCRATCH = 2'd3
  } port_e;

  logic          run_q;
  logic          ack_q, ack_d;
  logic [7:0]    rdata_q, rdata_d;
  logic [7:0]    mem_q [TX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    rx_buf_q, rx_buf_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          tx_drop_q, tx_drop_d;
  logic [7:0]    scratch_q, scratch_d;

  logic  hit, wr_en, rd_en, rx_en, pop, push, drop_set, status_rd, rx_rd, tx_full, tx_empty;
  port_e port;

  assign tx_full  = (count_q == FULL_C);
  assign tx_empty = (count_q == '0);
  assign tx_valid = !tx_empty;
  assign tx_data  = tx_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign io_ack   = ack_q;
  assign io_rdata = rdata_q;

  // Release flop: requests are ignored on the first posedge after res rises.
  always_ff @(posedge clk or negedge res) begin
    if (!res) run_q <= 1'b0;
    else      run_q <= 1'b1;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hit       = (io_addr[7:2] == BASE[7:2]);
    port      = port_e'(io_addr[1:0]);
    wr_en     = run_q & io_wr;
    rd_en     = run_q & io_rd & ~io_wr;
    rx_en     = run_q & rx_strobe;
    pop       = tx_valid & tx_ready;
    push      = wr_en & hit & (port == PORT_TX) & (~tx_full | pop);
    drop_set  = wr_en & hit & (port == PORT_TX) & tx_full & ~pop;
    status_rd = rd_en & hit & (port == PORT_STATUS);
    rx_rd     = rd_en & hit & (port == PORT_RX);

    ack_d   = wr_en | rd_en;
    rdata_d = 8'h00;
    if (rd_en) begin
      if (!hit) begin
        rdata_d = 8'hFF;
      end else begin
        case (port)
          PORT_STATUS:  rdata_d = {3'b000, tx_drop_q, rx_overrun_q, rx_valid_q, tx_empty, tx_full};
          PORT_RX:      rdata_d = rx_buf_q;
          PORT_SCRATCH: rdata_d = scratch_q;
          default:      rdata_d = 8'h00;
        endcase
      end
    end

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Sticky sets are applied after the read-clear so a same-cycle event is kept.
    tx_drop_d    = (tx_drop_q & ~status_rd) | drop_set;
    rx_overrun_d = (rx_overrun_q & ~status_rd) | (rx_en & rx_valid_q & ~rx_rd);
    rx_buf_d     = rx_en ? rx_data : rx_buf_q;
    rx_valid_d   = rx_en ? 1'b1 : (rx_rd ? 1'b0 : rx_valid_q);
    scratch_d    = (wr_en & hit & (port == PORT_SCRATCH)) ? io_wdata : scratch_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      ack_q        <= 1'b0;
      rdata_q      <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rx_buf_q     <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      tx_drop_q    <= 1'b0;
      scratch_q    <= 8'h00;
    end else begin
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rx_buf_q     <= rx_buf_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      tx_drop_q    <= tx_drop_d;
      scratch_q    <= scratch_d;
    end
  end

  // NOTE: FIFO storage is not reset; count gates tx_data, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io_wdata;
  end

endmodule

// File: tb/tb_goofy_io_responder.sv
// Self-checking bench for goofy_io_responder: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_goofy_io_responder;

  localparam logic [7:0] BASE  = 8'hF0;
  localparam int         DEPTH = 8;

  logic       clk, res;
  logic [7:0] io_addr, io_wdata, io_rdata, tx_data, rx_data;
  logic       io_wr, io_rd, io_ack, tx_valid, tx_ready, rx_strobe;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [7:0] m_q[$];
  bit         m_drop, m_ovr, m_rxv, m_run;
  logic [7:0] m_rxb, m_scr;

  goofy_io_responder #(.BASE(BASE), .TX_DEPTH(DEPTH)) dut (
    .clk(clk), .res(res),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_wr(io_wr), .io_rd(io_rd),
    .io_rdata(io_rdata), .io_ack(io_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_strobe(rx_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_drop = 0; m_ovr = 0; m_rxv = 0; m_run = 0;
    m_rxb = 8'h00; m_scr = 8'h00;
  endtask

  // One clock: drive inputs, advance the model, step the clock, compare.
  task automatic do_cycle(input logic wr, input logic rd, input logic [7:0] addr,
                          input logic [7:0] wdata, input logic strb,
                          input logic [7:0] rxd, input logic rdy);
    logic       e_ack;
    logic [7:0] e_rdata;
    bit         mapped, pop, st_rd, rx_rd;
    int         off;
    io_wr = wr; io_rd = rd; io_addr = addr; io_wdata = wdata;
    rx_strobe = strb; rx_data = rxd; tx_ready = rdy;
    mapped  = (addr >= BASE) && (addr <= BASE + 8'd3);
    off     = int'(addr - BASE);
    e_ack   = 1'b0;
    e_rdata = 8'h00;
    if (m_run) begin
      e_ack = wr | rd;
      st_rd = rd && !wr && mapped && off == 1;
      rx_rd = rd && !wr && mapped && off == 2;
      if (rd && !wr) begin
        if (!mapped)      e_rdata = 8'hFF;
        else if (off == 1) e_rdata = {3'b000, m_drop, m_ovr, m_rxv,
                                      m_q.size() == 0, m_q.size() == DEPTH};
        else if (off == 2) e_rdata = m_rxb;
        else if (off == 3) e_rdata = m_scr;
      end
      if (st_rd) begin m_drop = 0; m_ovr = 0; end
      pop = (m_q.size() != 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (wr && mapped && off == 0) begin
        if (m_q.size() < DEPTH) m_q.push_back(wdata);
        else                    m_drop = 1;
      end
      if (wr && mapped && off == 3) m_scr = wdata;
      if (strb) begin
        if (m_rxv && !rx_rd) m_ovr = 1;
        m_rxb = rxd;
        m_rxv = 1;
      end else if (rx_rd) begin
        m_rxv = 0;
      end
    end
    m_run = 1;
    @(posedge clk);
    #1;
    check("ack", io_ack, e_ack);
    if (e_ack) check("rdata", io_rdata, e_rdata);
    check("tx_valid", tx_valid, m_q.size() != 0);
    check("tx_data", tx_data, (m_q.size() != 0) ? m_q[0] : 8'h00);
    io_wr = 0; io_rd = 0; rx_strobe = 0;
  endtask

  task automatic wr_io(input logic [7:0] a, input logic [7:0] d, input logic rdy);
    do_cycle(1'b1, 1'b0, a, d, 1'b0, 8'h00, rdy);
  endtask
  task automatic rd_io(input logic [7:0] a, input logic rdy);
    do_cycle(1'b0, 1'b1, a, 8'h00, 1'b0, 8'h00, rdy);
  endtask
  task automatic idle(input logic rdy);
    do_cycle(1'b0, 1'b0, BASE, 8'h00, 1'b0, 8'h00, rdy);
  endtask
  task automatic rx_in(input logic [7:0] d);
    do_cycle(1'b0, 1'b0, BASE, 8'h00, 1'b1, d, 1'b0);
  endtask

  function automatic logic [7:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 11));
    if (r < 4)  return BASE;
    if (r < 10) return BASE + 8'($urandom_range(1, 4));
    return 8'($urandom);
  endfunction

  initial begin
    res = 1'b0; io_wr = 0; io_rd = 0; io_addr = 8'h00; io_wdata = 8'h00;
    rx_strobe = 0; rx_data = 8'h00; tx_ready = 0;
    model_reset();
    #1;
    check("rst_ack", io_ack, 1'b0);
    check("rst_rdata", io_rdata, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    res = 1'b1;

    // First posedge after release ignores requests; the second is live.
    wr_io(8'hF3, 8'hAA, 1'b0);
    rd_io(8'hF1, 1'b0);
    check("idle_status", io_rdata, 8'h02);
    check("idle_ack", io_ack, 1'b1);
    idle(1'b0);
    check("ack_one_cycle", io_ack, 1'b0);
    rd_io(8'hF3, 1'b0);
    check("scratch_after_release", io_rdata, 8'h00);

    // TX ordering
    wr_io(8'hF0, 8'h41, 1'b0);
    wr_io(8'hF0, 8'h42, 1'b0);
    wr_io(8'hF0, 8'h43, 1'b0);
    check("tx_head", tx_data, 8'h41);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("tx_drained", tx_valid, 1'b0);

    // Overflow
    for (int i = 0; i < 9; i++) wr_io(8'hF0, 8'(i), 1'b0);
    rd_io(8'hF1, 1'b0);
    check("ovf_status", io_rdata, 8'h11);
    rd_io(8'hF1, 1'b0);
    check("ovf_status_cleared", io_rdata, 8'h01);
    for (int i = 0; i < 7; i++) idle(1'b1);
    check("ovf_last_kept", tx_data, 8'h07);
    idle(1'b1);
    check("ovf_drop_lost", tx_valid, 1'b0);

    // Full with simultaneous pop
    for (int i = 0; i < 8; i++) wr_io(8'hF0, 8'hA0 + 8'(i), 1'b0);
    wr_io(8'hF0, 8'h99, 1'b1);
    rd_io(8'hF1, 1'b0);
    check("fullpop_status", io_rdata, 8'h01);
    for (int i = 0; i < 7; i++) idle(1'b1);
    check("fullpop_last", tx_data, 8'h99);
    idle(1'b1);

    // RX overrun and same-cycle read+strobe
    rx_in(8'h10);
    rx_in(8'h20);
    rd_io(8'hF1, 1'b0);
    check("rx_ovr_status", io_rdata, 8'h0E);
    rd_io(8'hF2, 1'b0);
    check("rx_data", io_rdata, 8'h20);
    rd_io(8'hF1, 1'b0);
    check("rx_status_after", io_rdata, 8'h02);
    rx_in(8'h30);
    do_cycle(1'b0, 1'b1, 8'hF2, 8'h00, 1'b1, 8'h31, 1'b0);
    check("rx_read_old", io_rdata, 8'h30);
    rd_io(8'hF1, 1'b0);
    check("rx_no_overrun", io_rdata, 8'h06);
    rd_io(8'hF2, 1'b0);

    // Decode edges
    wr_io(8'hF3, 8'h5A, 1'b0);
    rd_io(8'hF3, 1'b0);
    check("scratch_rb", io_rdata, 8'h5A);
    rd_io(8'hF4, 1'b0);
    check("unmapped_rd", io_rdata, 8'hFF);
    check("unmapped_ack", io_ack, 1'b1);
    do_cycle(1'b1, 1'b1, 8'hF3, 8'h77, 1'b0, 8'h00, 1'b0);
    check("wr_rd_rdata", io_rdata, 8'h00);
    idle(1'b0);
    check("wr_rd_single_ack", io_ack, 1'b0);
    rd_io(8'hF3, 1'b0);
    check("wr_rd_scratch", io_rdata, 8'h77);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int   r;
      logic wr, rd, rdy;
      r   = int'($urandom_range(0, 9));
      wr  = (r < 4) || (r == 9);
      rd  = (r >= 4 && r < 7) || (r == 9);
      rdy = (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      do_cycle(wr, rd, rand_addr(), 8'($urandom), $urandom_range(0, 4) == 0,
               8'($urandom), rdy);
    end

    // Reset mid-drain
    for (int i = 0; i < 3; i++) wr_io(8'hF0, 8'hC0 + 8'(i), 1'b0);
    rd_io(8'hF1, 1'b1);
    res = 1'b0;
    #1;
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    check("mid_rst_tx_data", tx_data, 8'h00);
    check("mid_rst_ack", io_ack, 1'b0);
    model_reset();
    @(posedge clk); #1;
    res = 1'b1;
    idle(1'b0);
    rd_io(8'hF1, 1'b0);
    check("post_rst_status", io_rdata, 8'h02);
    idle(1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
